// File: rtl/led_gen_pkg.sv
// Shared definitions for the LED pattern generator:
// pattern mode encodings and timebase helper functions.
package led_gen_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED pattern channel: mode/half-period registers, phase timer, lit bit.
// Burst slot counter present only when LEDGEN_BURST_EN is defined.
module led_channel
    import led_gen_pkg::*;
#(
    parameter int PER_W        = 16,
`ifdef LEDGEN_BURST_EN
    parameter int BURST_LEN    = 3,
    parameter int GAP_HALVES   = 4,
`endif
    parameter int DEFAULT_HALF = 500
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_tick,
    input  logic             i_wr,
    input  logic [1:0]       i_mode,
    input  logic [PER_W-1:0] i_half,
    output logic             o_lit,
    output logic             o_cycle
);

`ifdef LEDGEN_BURST_EN
    localparam int SLOT_N = 2 * BURST_LEN + GAP_HALVES;
    localparam int SLOT_W = clog2_min1(SLOT_N);

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;
    logic [SLOT_W-1:0] slot_nx;
`endif

    mode_e            mode_q;
    mode_e            mode_d;
    logic [PER_W-1:0] half_q;
    logic [PER_W-1:0] half_d;
    logic [PER_W-1:0] phase_q;
    logic [PER_W-1:0] phase_d;
    logic             lit_q;
    logic             lit_d;
    logic             cycle_q;
    logic             cycle_d;
    logic [PER_W-1:0] half_eff;
    logic             wrap;

    always_comb begin
        half_eff = (half_q == '0) ? PER_W'(1) : half_q;
        wrap     = i_tick && (phase_q == half_eff - 1'b1);
        mode_d   = mode_q;
        half_d   = half_q;
        phase_d  = phase_q;
        lit_d    = lit_q;
        cycle_d  = 1'b0;
`ifdef LEDGEN_BURST_EN
        slot_d   = slot_q;
        slot_nx  = '0;
`endif
        if (i_wr) begin
            // A write restarts the pattern; the same-cycle tick is dropped.
            mode_d  = mode_e'(i_mode);
            half_d  = i_half;
            phase_d = '0;
            lit_d   = (mode_e'(i_mode) == MODE_ON);
`ifdef LEDGEN_BURST_EN
            slot_d  = '0;
`endif
        end else begin
            unique case (mode_q)
                MODE_OFF: begin
                    lit_d   = 1'b0;
                    phase_d = '0;
`ifdef LEDGEN_BURST_EN
                    slot_d  = '0;
`endif
                end
                MODE_ON: begin
                    lit_d   = 1'b1;
                    phase_d = '0;
`ifdef LEDGEN_BURST_EN
                    slot_d  = '0;
`endif
                end
`ifdef LEDGEN_BURST_EN
                MODE_BLINK: begin
                    if (i_tick) phase_d = wrap ? '0 : phase_q + 1'b1;
                    if (wrap) begin
                        lit_d   = ~lit_q;
                        cycle_d = ~lit_q;
                    end
                end
                MODE_BURST: begin
                    if (i_tick) phase_d = wrap ? '0 : phase_q + 1'b1;
                    if (wrap) begin
                        slot_nx = (slot_q == SLOT_W'(SLOT_N - 1)) ?
                                  '0 : slot_q + 1'b1;
                        slot_d  = slot_nx;
                        lit_d   = (32'(slot_nx) < 2 * BURST_LEN) &&
                                  !slot_nx[0];
                        cycle_d = (slot_nx == '0);
                    end
                end
`else
                MODE_BLINK, MODE_BURST: begin
                    if (i_tick) phase_d = wrap ? '0 : phase_q + 1'b1;
                    if (wrap) begin
                        lit_d   = ~lit_q;
                        cycle_d = ~lit_q;
                    end
                end
`endif
                default: begin
                    lit_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mode_q  <= MODE_OFF;
            half_q  <= PER_W'(DEFAULT_HALF);
            phase_q <= '0;
            lit_q   <= 1'b0;
            cycle_q <= 1'b0;
`ifdef LEDGEN_BURST_EN
            slot_q  <= '0;
`endif
        end else begin
            mode_q  <= mode_d;
            half_q  <= half_d;
            phase_q <= phase_d;
            lit_q   <= lit_d;
            cycle_q <= cycle_d;
`ifdef LEDGEN_BURST_EN
            slot_q  <= slot_d;
`endif
        end
    end

    assign o_lit   = lit_q;
    assign o_cycle = cycle_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler, write decode, channels.
// Optional BURST mode enabled by defining LEDGEN_BURST_EN.
module led_pattern_gen
    import led_gen_pkg::*;
#(
    parameter int CLK_HZ       = 25_000_000,
    parameter int TICK_HZ      = 1_000,
    parameter int N_CH         = 4,
    parameter int PER_W        = 16,
    parameter int DEFAULT_HALF = 500,
    parameter int BURST_LEN    = 3,
    parameter int GAP_HALVES   = 4,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                                     i_clk,
    input  logic                                     i_reset,
    input  logic                                     i_cfg_wr,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] i_cfg_ch,
    input  logic [1:0]                               i_cfg_mode,
    input  logic [PER_W-1:0]                         i_cfg_half,
    output logic [N_CH-1:0]                          o_led,
    output logic [N_CH-1:0]                          o_cycle,
    output logic                                     o_tick
);

    localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
    localparam int CNT_W = clog2_min1(DIV);

    if (DIV < 2 || N_CH < 1 || N_CH > 8 ||
        BURST_LEN < 1 || GAP_HALVES < 0) begin : g_bad_cfg
        $error("led_pattern_gen: illegal parameter set");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick;
    logic             ch_ok;
    logic [N_CH-1:0]  wr_ch;
    logic [N_CH-1:0]  lit;
    logic [N_CH-1:0]  cyc;

    always_comb begin
        tick  = (cnt_q == CNT_W'(DIV - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    // Out-of-range channel numbers match no channel and are dropped.
    always_comb begin
        ch_ok = (32'(i_cfg_ch) < 32'(N_CH));
        wr_ch = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (i_cfg_wr && ch_ok && (32'(i_cfg_ch) == 32'(i)))
                wr_ch[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        led_channel #(
            .PER_W       (PER_W),
`ifdef LEDGEN_BURST_EN
            .BURST_LEN   (BURST_LEN),
            .GAP_HALVES  (GAP_HALVES),
`endif
            .DEFAULT_HALF(DEFAULT_HALF)
        ) u_ch (
            .i_clk  (i_clk),
            .i_reset(i_reset),
            .i_tick (tick),
            .i_wr   (wr_ch[g]),
            .i_mode (i_cfg_mode),
            .i_half (i_cfg_half),
            .o_lit  (lit[g]),
            .o_cycle(cyc[g])
        );
    end

    assign o_led   = (ACTIVE_LOW != 0) ? ~lit : lit;
    assign o_cycle = cyc;
    assign o_tick  = tick;

endmodule
